// File: rtl/rd_axil_pkg.sv
// Shared constants and FSM encodings for the RD AXI4-Lite register bank.
// Response codes and the read-error pattern are common to every bank built on it.
package rd_axil_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam int unsigned REG_IDX_LSB = 2;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic {
        WIdle = 1'b0,
        WResp = 1'b1
    } wr_state_e;

    typedef enum logic {
        RIdle = 1'b0,
        RData = 1'b1
    } rd_state_e;

endpackage

// File: rtl/rd_axil_strb_merge.sv
// Byte-strobe merge: each byte of the result comes from new_data_i where its strobe
// is set, otherwise from old_data_i.
module rd_axil_strb_merge #(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0]   old_data_i,
    input  logic [DataWidth-1:0]   new_data_i,
    input  logic [DataWidth/8-1:0] strb_i,
    output logic [DataWidth-1:0]   merged_o
);

    always_comb begin
        merged_o = old_data_i;
        for (int b = 0; b < DataWidth / 8; b++) begin
            if (strb_i[b]) begin
                merged_o[b*8 +: 8] = new_data_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/rd_axil_reg_slave.sv
// AXI4-Lite slave with four 32-bit RD registers and per-register write pulses.
// Define RD_REG_ERR_RESP_EN to decode the full address and answer accesses >= 0x10 with SLVERR.
module rd_axil_reg_slave
    import rd_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
`ifdef RD_REG_ERR_RESP_EN
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
`else
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
`endif
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    localparam int unsigned IdxW = $clog2(NUM_REGS);

    wr_state_e                     wr_state_q;
    rd_state_e                     rd_state_q;
    logic                          awready_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;
    logic                          arready_q;
    logic                          rvalid_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]           wr_pulse_q;

    logic [IdxW-1:0]               wr_idx;
    logic [IdxW-1:0]               rd_idx;
    logic                          wr_err;
    logic                          rd_err;
    logic                          wr_hs;
    logic                          rd_hs;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_merged;
    logic                          unused_ok;

    assign wr_idx = S_AXI_AWADDR[REG_IDX_LSB +: IdxW];
    assign rd_idx = S_AXI_ARADDR[REG_IDX_LSB +: IdxW];

`ifdef RD_REG_ERR_RESP_EN
    assign wr_err = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:REG_IDX_LSB+IdxW];
    assign rd_err = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:REG_IDX_LSB+IdxW];
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    // Protection bits and the byte-offset bits never affect decode.
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[REG_IDX_LSB-1:0], S_AXI_ARADDR[REG_IDX_LSB-1:0]};

    assign wr_hs = (wr_state_q == WIdle) && awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs = (rd_state_q == RIdle) && arready_q && S_AXI_ARVALID;

    rd_axil_strb_merge #(
        .DataWidth (C_S_AXI_DATA_WIDTH)
    ) u_strb_merge (
        .old_data_i (regs_q[wr_idx]),
        .new_data_i (S_AXI_WDATA),
        .strb_i     (S_AXI_WSTRB),
        .merged_o   (wr_merged)
    );

    // Write channel: AW and W are only ever accepted together.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WIdle;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            unique case (wr_state_q)
                WIdle: begin
                    if (wr_hs) begin
                        awready_q  <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        wr_state_q <= WResp;
                        if (!wr_err) begin
                            regs_q[wr_idx]     <= wr_merged;
                            wr_pulse_q[wr_idx] <= 1'b1;
                        end
                    end else begin
                        awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID;
                    end
                end
                WResp: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= WIdle;
                    end
                end
                default: wr_state_q <= WIdle;
            endcase
        end
    end

    // Read channel: data is sampled from the registers on the AR handshake edge, so a
    // write landing on that same edge is not yet visible.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= RIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            unique case (rd_state_q)
                RIdle: begin
                    if (rd_hs) begin
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_err ? RD_ERR_DATA : regs_q[rd_idx];
                        rresp_q    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rd_state_q <= RData;
                    end else begin
                        arready_q <= !arready_q && S_AXI_ARVALID;
                    end
                end
                RData: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q   <= 1'b0;
                        rd_state_q <= RIdle;
                    end
                end
                default: rd_state_q <= RIdle;
            endcase
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs_q[i];
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_rd_axil_reg_slave.sv
// Randomised self-checking bench for rd_axil_reg_slave against a register-array model.
// Honours RD_REG_ERR_RESP_EN when compiled with it.
module tb_rd_axil_reg_slave;

`ifdef RD_REG_ERR_RESP_EN
    localparam int AW     = 8;
    localparam bit ERR_EN = 1'b1;
`else
    localparam int AW     = 4;
    localparam bit ERR_EN = 1'b0;
`endif

    logic           tb_ACLK = 1'b0;
    logic           tb_ARESET;
    logic [AW-1:0]  awaddr, araddr;
    logic [2:0]     awprot, arprot;
    logic           awvalid, awready, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rvalid, rready;
    logic [31:0]    wdata, rdata;
    logic [3:0]     wstrb;
    logic [1:0]     bresp, rresp;
    logic [127:0]   reg_out;
    logic [3:0]     reg_wr_pulse;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [31:0]    model [4];

    always #5 tb_ACLK = ~tb_ACLK;

    rd_axil_reg_slave dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESET  (tb_ARESET),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    // ---------------- reference model ----------------
    function automatic bit in_range(logic [AW-1:0] a);
        return !ERR_EN || (int'(a) < 16);
    endfunction

    function automatic int reg_idx(logic [AW-1:0] a);
        return (int'(a) % 16) / 4;
    endfunction

    function automatic logic [1:0] exp_resp(logic [AW-1:0] a);
        return in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_rdata(logic [AW-1:0] a);
        return in_range(a) ? model[reg_idx(a)] : 32'hDEADBEEF;
    endfunction

    function automatic logic [3:0] exp_pulse(logic [AW-1:0] a);
        return in_range(a) ? 4'(1 << reg_idx(a)) : 4'h0;
    endfunction

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        if (in_range(a)) model[reg_idx(a)] = (model[reg_idx(a)] & ~mask) | (d & mask);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endtask

    // ---------------- bus drivers (no checking) ----------------
    task automatic do_reset();
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        tb_ARESET = 1'b1;
        repeat (2) @(posedge tb_ACLK);
        #1 tb_ARESET = 1'b0;
        model_clear();
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [3:0] p1,
                             output logic [3:0] p2, output bit to);
        int n;
        bit hs;
        to = 0; p1 = 0; p2 = 0; resp = 2'b11;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin
            @(negedge tb_ACLK);
            hs = awready && wready;
            n++;
        end
        if (!hs) begin
            to = 1; awvalid = 0; wvalid = 0;
            return;
        end
        @(posedge tb_ACLK);
        #1 awvalid = 0; wvalid = 0;
        p1 = reg_wr_pulse;
        @(posedge tb_ACLK);
        #1 p2 = reg_wr_pulse;
        bready = 1; n = 0; hs = 0;
        while (!hs && n < 50) begin
            @(negedge tb_ACLK);
            hs = bvalid;
            n++;
        end
        resp = bresp;
        if (!hs) to = 1;
        @(posedge tb_ACLK);
        #1 bready = 0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output logic rv1, output bit to);
        int n;
        bit hs;
        to = 0; d = 0; resp = 2'b11; rv1 = 0;
        araddr = a; arvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin
            @(negedge tb_ACLK);
            hs = arready;
            n++;
        end
        if (!hs) begin
            to = 1; arvalid = 0;
            return;
        end
        @(posedge tb_ACLK);
        #1 arvalid = 0;
        rv1 = rvalid;
        rready = 1; n = 0; hs = 0;
        while (!hs && n < 50) begin
            @(negedge tb_ACLK);
            hs = rvalid;
            n++;
        end
        d = rdata; resp = rresp;
        if (!hs) to = 1;
        @(posedge tb_ACLK);
        #1 rready = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [1:0] r; logic [3:0] p1, p2; bit to;
        do_reset();
        axi_write(AW'(8), 32'h1234_5678, 4'hF, r, p1, p2, to);
        do_reset();
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b want 00000", {awready, wready, bvalid, arready, rvalid});
        end
        n_checks++;
        if ({bresp, rresp} !== 4'b0) begin
            n_fail++; $display("FAIL reset_resp: got %b want 0000", {bresp, rresp});
        end
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        n_checks++;
        if (reg_out !== 128'h0 || reg_wr_pulse !== 4'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h/%b want 0/0", reg_out, reg_wr_pulse);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] vals [4];
        logic [31:0] d; logic [1:0] r; logic [3:0] p1, p2; logic rv1; bit to;
        logic [AW-1:0] a;
        vals[0] = 32'h0101FFFF; vals[1] = 32'habcd0001;
        vals[2] = 32'hdead0011; vals[3] = 32'hbeef0011;
        for (int i = 0; i < 4; i++) begin
            a = AW'(i * 4);
            axi_write(a, vals[i], 4'hF, r, p1, p2, to);
            model_write(a, vals[i], 4'hF);
            n_checks++;
            if (to || r !== 2'b00) begin
                n_fail++; $display("FAIL seq_bresp[%0d]: got %b to=%0d want 00", i, r, to);
            end
            n_checks++;
            if (p1 !== 4'(1 << i) || p2 !== 4'h0) begin
                n_fail++; $display("FAIL seq_pulse[%0d]: got %b,%b want %b,0000", i, p1, p2, 4'(1 << i));
            end
            axi_read(a, d, r, rv1, to);
            n_checks++;
            if (to || d !== vals[i] || r !== 2'b00 || rv1 !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_read[%0d]: got %h resp %b rv1 %b want %h 00 1", i, d, r, rv1, vals[i]);
            end
        end
        n_checks++;
        if (reg_out !== model_vec()) begin
            n_fail++; $display("FAIL seq_reg_out: got %h want %h", reg_out, model_vec());
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; logic [3:0] p1, p2; logic rv1; bit to;
        axi_write(AW'(4), 32'habcd0001, 4'hF, r, p1, p2, to);
        model_write(AW'(4), 32'habcd0001, 4'hF);
        axi_write(AW'(4), 32'h11223344, 4'b0101, r, p1, p2, to);
        model_write(AW'(4), 32'h11223344, 4'b0101);
        axi_read(AW'(4), d, r, rv1, to);
        n_checks++;
        if (to || d !== 32'hab220044 || d !== model[1]) begin
            n_fail++; $display("FAIL strobe_read: got %h want ab220044", d);
        end
        // Zero strobe: no data change, but a response and a pulse.
        axi_write(AW'(4), 32'hFFFF_FFFF, 4'h0, r, p1, p2, to);
        n_checks++;
        if (to || r !== 2'b00 || p1 !== 4'b0010 || reg_out[63:32] !== 32'hab220044) begin
            n_fail++;
            $display("FAIL strobe_zero: got resp %b pulse %b reg1 %h want 00 0010 ab220044",
                     r, p1, reg_out[63:32]);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, wd; logic [1:0] r; logic [3:0] p1, p2, s; logic rv1; bit to;
        logic [AW-1:0] a;
        int amax;
        amax = ERR_EN ? 31 : 15;
        for (int i = 0; i < 30; i++) begin
            a = AW'($urandom_range(0, amax));
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, wd, s, r, p1, p2, to);
            n_checks++;
            if (to || r !== exp_resp(a) || p1 !== exp_pulse(a) || p2 !== 4'h0) begin
                n_fail++;
                $display("FAIL rand_write[%0d]: addr %h got resp %b pulse %b want %b %b",
                         i, a, r, p1, exp_resp(a), exp_pulse(a));
            end
            model_write(a, wd, s);
            n_checks++;
            if (reg_out !== model_vec()) begin
                n_fail++; $display("FAIL rand_reg_out[%0d]: got %h want %h", i, reg_out, model_vec());
            end
            a = AW'($urandom_range(0, amax));
            axi_read(a, d, r, rv1, to);
            n_checks++;
            if (to || d !== exp_rdata(a) || r !== exp_resp(a)) begin
                n_fail++;
                $display("FAIL rand_read[%0d]: addr %h got %h/%b want %h/%b",
                         i, a, d, r, exp_rdata(a), exp_resp(a));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] wd, d0; logic [1:0] r0; logic [1:0] r; logic rv1; bit to; bit hs;
        int n;
        wd = $urandom;
        awaddr = AW'(8); wdata = wd; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin @(negedge tb_ACLK); hs = awready; n++; end
        n_checks++;
        if (!hs) begin n_fail++; $display("FAIL bp_aw_timeout: got no AWREADY want handshake"); end
        @(posedge tb_ACLK);
        #1 wdata = ~wd; awaddr = AW'(0);  // keep a second write pending during the stall
        model_write(AW'(8), wd, 4'hF);
        r0 = bresp;
        for (int c = 0; c < 5; c++) begin
            @(negedge tb_ACLK);
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== r0 || awready !== 1'b0 || wready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_write_hold[%0d]: got bv %b bresp %b awr %b wr %b want 1 %b 0 0",
                         c, bvalid, bresp, awready, wready, r0);
            end
        end
        @(posedge tb_ACLK);
        #1 awvalid = 0; wvalid = 0; bready = 1;
        @(posedge tb_ACLK);
        #1 bready = 0;
        n_checks++;
        if (reg_out !== model_vec()) begin
            n_fail++; $display("FAIL bp_write_regs: got %h want %h", reg_out, model_vec());
        end

        araddr = AW'(8); arvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin @(negedge tb_ACLK); hs = arready; n++; end
        n_checks++;
        if (!hs) begin n_fail++; $display("FAIL bp_ar_timeout: got no ARREADY want handshake"); end
        @(posedge tb_ACLK);
        #1 araddr = AW'(0);
        d0 = rdata;
        for (int c = 0; c < 5; c++) begin
            @(negedge tb_ACLK);
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== model[2] || rdata !== d0 || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_read_hold[%0d]: got rv %b rdata %h arr %b want 1 %h 0",
                         c, rvalid, rdata, arready, model[2]);
            end
        end
        @(posedge tb_ACLK);
        #1 arvalid = 0; rready = 1;
        @(posedge tb_ACLK);
        #1 rready = 0;
        axi_read(AW'(0), d0, r, rv1, to);
        n_checks++;
        if (to || d0 !== model[0]) begin
            n_fail++; $display("FAIL bp_reg0_untouched: got %h want %h", d0, model[0]);
        end
    endtask

    task automatic test_split();
        logic [31:0] wd; bit hs; int n;
        wd = $urandom;
        awaddr = AW'(12); wdata = wd; wstrb = 4'hF; awvalid = 1; wvalid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge tb_ACLK);
            n_checks++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                n_fail++; $display("FAIL split_early_ready[%0d]: got %b%b want 00", c, awready, wready);
            end
        end
        @(posedge tb_ACLK);
        #1 wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin
            @(negedge tb_ACLK);
            n_checks++;
            if (awready !== wready) begin
                n_fail++; $display("FAIL split_ready_pair: got aw %b w %b want equal", awready, wready);
            end
            hs = awready && wready;
            n++;
        end
        n_checks++;
        if (!hs) begin n_fail++; $display("FAIL split_timeout: got no handshake want handshake"); end
        @(posedge tb_ACLK);
        #1 awvalid = 0; wvalid = 0; bready = 1;
        model_write(AW'(12), wd, 4'hF);
        @(posedge tb_ACLK);
        #1 bready = 0;
        n_checks++;
        if (reg_out[127:96] !== wd) begin
            n_fail++; $display("FAIL split_reg3: got %h want %h", reg_out[127:96], wd);
        end
    endtask

    task automatic test_reset_mid_write();
        bit hs; int n;
        awaddr = AW'(4); wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin @(negedge tb_ACLK); hs = awready; n++; end
        @(posedge tb_ACLK);
        #1 awvalid = 0; wvalid = 0;
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_bvalid_pre: got %b want 1", bvalid);
        end
        tb_ARESET = 1;
        @(posedge tb_ACLK);
        #1 tb_ARESET = 0;
        model_clear();
        n_checks++;
        if (bvalid !== 1'b0 || reg_out !== 128'h0 || reg_wr_pulse !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_state: got bv %b regs %h pulse %b want 0 0 0",
                     bvalid, reg_out, reg_wr_pulse);
        end
        repeat (3) @(posedge tb_ACLK);
        #1;
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_b: got bvalid %b want 0", bvalid);
        end
    endtask

    task automatic test_alias();
        logic [31:0] d; logic [1:0] r; logic [3:0] p1, p2; logic rv1; bit to;
        logic [AW-1:0] a;
        a = AW'(20);
        axi_write(a, 32'h5A5A_1234, 4'hF, r, p1, p2, to);
        model_write(a, 32'h5A5A_1234, 4'hF);
        n_checks++;
        if (to || r !== exp_resp(a) || p1 !== exp_pulse(a) || reg_out !== model_vec()) begin
            n_fail++;
            $display("FAIL alias_write: got resp %b pulse %b regs %h want %b %b %h",
                     r, p1, reg_out, exp_resp(a), exp_pulse(a), model_vec());
        end
        axi_read(a, d, r, rv1, to);
        n_checks++;
        if (to || d !== exp_rdata(a) || r !== exp_resp(a)) begin
            n_fail++; $display("FAIL alias_read: got %h/%b want %h/%b", d, r, exp_rdata(a), exp_resp(a));
        end
    endtask

    initial begin
        awprot = 3'b000; arprot = 3'b000;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        model_clear();
        test_reset();
        test_sequential();
        test_strobe();
        test_backpressure();
        test_split();
        test_random();
        test_alias();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
